bnn_vitals_binarizer: RTL

- **Position:** upstream front-end of the BNN medical classifier.
- **Input:** a stream of eight 8-bit vital-sign samples per frame, channel 0 first, accepted through a valid/ready handshake.
- **Binarization:** each sample is compared with a programmable per-channel threshold, with optional per-channel inverted polarity. The eight resulting bits are packed into a feature vector.
- **Output:** the vector is held for the classifier's XNOR/popcount stage, with a one-cycle valid pulse per completed frame.

---
 rtl/bnn_vitals_binarizer_pkg.sv | 19 +
 rtl/bnn_vitals_binarizer_chan_cmp.sv | 18 +
 rtl/bnn_vitals_binarizer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bnn_vitals_binarizer_pkg.sv
// Shared constants and types for the BNN vital-sign binarizer front-end.
// Feature width is tied to the classifier's XNOR/popcount stage, so N_CH stays at 8.
package bnn_pkg;

  localparam int N_CH   = 8;
  localparam int DATA_W = 8;
  localparam int CH_W   = $clog2(N_CH);
  localparam int CNT_W  = 8;

  localparam logic [3:0]        CFG_ADDR_POL = 4'd8;
  localparam logic [DATA_W-1:0] THR_RESET    = 8'h80;
  localparam logic [CH_W-1:0]   LAST_CH      = CH_W'(N_CH - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

endpackage

// File: rtl/bnn_vitals_binarizer_chan_cmp.sv
// Single-channel binarizer: threshold compare with optional polarity inversion.
// Pure combinational; the top feeds it through a channel-index mux.
module bnn_chan_cmp
  import bnn_pkg::*;
(
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] thr_i,
  input  logic              pol_i,
  output logic              bit_o
);

  logic ge;

  // Inverted polarity turns ">= thr" into "< thr", which is exactly the complement.
  assign ge    = (sample_i >= thr_i);
  assign bit_o = pol_i ? ~ge : ge;

endmodule

// File: rtl/bnn_vitals_binarizer.sv
// Vital-sign binarizer: collects eight samples per frame, thresholds each one and
// presents the packed feature vector with a one-cycle valid pulse.
module bnn_vitals_binarizer
  import bnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [N_CH-1:0]   feat_out,
  output logic              feat_valid,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [CH_W-1:0]    ch_idx_q, ch_idx_d;
  logic [N_CH-1:0]    acc_q, acc_d, acc_upd;
  logic [N_CH-1:0]    feat_q, feat_d;
  logic               feat_valid_q, feat_valid_d;
  logic               frame_err_q, frame_err_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic [DATA_W-1:0]  thr_q [N_CH];
  logic [DATA_W-1:0]  thr_d [N_CH];
  logic [N_CH-1:0]    pol_q, pol_d;

  logic               accept;
  logic               is_last_ch;
  logic               frame_done;
  logic               framing_bad;
  logic [DATA_W-1:0]  sel_thr;
  logic               sel_pol;
  logic               cmp_bit;

  // Config register file; the compare below always sees the pre-edge values.
  always_comb begin
    pol_d = pol_q;
    for (int i = 0; i < N_CH; i++) begin
      thr_d[i] = thr_q[i];
    end
    if (cfg_we) begin
      if (cfg_addr == CFG_ADDR_POL) begin
        pol_d = cfg_data[N_CH-1:0];
      end else if (cfg_addr < 4'(N_CH)) begin
        thr_d[cfg_addr[CH_W-1:0]] = cfg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        thr_q[i] <= THR_RESET;
      end
    end else begin
      pol_q <= pol_d;
      for (int i = 0; i < N_CH; i++) begin
        thr_q[i] <= thr_d[i];
      end
    end
  end

  assign sel_thr = thr_q[ch_idx_q];
  assign sel_pol = pol_q[ch_idx_q];

  bnn_chan_cmp u_cmp (
    .sample_i (s_data),
    .thr_i    (sel_thr),
    .pol_i    (sel_pol),
    .bit_o    (cmp_bit)
  );

  // ready_q is a registered copy of "next state is COLLECT", so it is low during reset.
  assign accept      = s_valid & ready_q;
  assign is_last_ch  = (ch_idx_q == LAST_CH);
  assign frame_done  = accept & s_last & is_last_ch;
  assign framing_bad = accept & (s_last ^ is_last_ch);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_acc
    assign acc_upd[gi] = (accept && (ch_idx_q == CH_W'(gi))) ? cmp_bit : acc_q[gi];
  end

  always_comb begin
    state_d      = state_q;
    ch_idx_d     = ch_idx_q;
    acc_d        = acc_upd;
    feat_d       = feat_q;
    feat_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      COLLECT: begin
        if (framing_bad) begin
          ch_idx_d    = '0;
          acc_d       = '0;
          frame_err_d = 1'b1;
        end else if (frame_done) begin
          feat_d       = acc_upd;
          feat_valid_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          acc_d        = '0;
          ch_idx_d     = '0;
          state_d      = EMIT;
        end else if (accept) begin
          ch_idx_d = ch_idx_q + CH_W'(1);
        end
      end
      EMIT: begin
        state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
    ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      ready_q      <= 1'b0;
      ch_idx_q     <= '0;
      acc_q        <= '0;
      feat_q       <= '0;
      feat_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      ch_idx_q     <= ch_idx_d;
      acc_q        <= acc_d;
      feat_q       <= feat_d;
      feat_valid_q <= feat_valid_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign s_ready    = ready_q;
  assign feat_out   = feat_q;
  assign feat_valid = feat_valid_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
